// File: rtl/stream_checker.sv
// stream_checker: self-checking sink for a dataflow graph output node.
// Requests items from the upstream out-operator, compares each accepted item
// with an affine golden sequence, applies periodic back-pressure and reports
// counts, the first failure and completion.
// Optional trace output is enabled by defining STREAM_CHECKER_TRACE_EN.
module stream_checker #(
   parameter int unsigned data_width   = 32,
   parameter int unsigned consumer_id  = 0,
   parameter int unsigned start_value  = 0,
   parameter int unsigned exp_mul      = 1,
   parameter int unsigned exp_add      = 0,
   parameter int unsigned max_items    = 5000,
   parameter int unsigned stall_every  = 0,
   parameter int unsigned stall_cycles = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  req_o,
   input  logic                  ack_i,
   input  logic [data_width-1:0] din_i,
   output logic [31:0]           count_o,
   output logic [31:0]           err_count_o,
   output logic                  first_err_valid_o,
   output logic [31:0]           first_err_index_o,
   output logic [data_width-1:0] first_err_data_o,
   output logic [31:0]           extra_count_o,
   output logic [31:0]           cycle_count_o,
   output logic                  done_o,
   output logic                  pass_o
);

   localparam int unsigned CNT_W = 32;

   // Golden sequence start point and slope, reduced modulo 2^data_width
   localparam logic [data_width-1:0] EXP_STEP = data_width'(exp_mul);
   localparam logic [data_width-1:0] EXP_INIT =
      data_width'(exp_mul) * data_width'(start_value) + data_width'(exp_add);

   localparam logic [CNT_W-1:0] MAX_ITEMS    = CNT_W'(max_items);
   localparam logic [CNT_W-1:0] STALL_EVERY  = CNT_W'(stall_every);
   localparam logic [CNT_W-1:0] STALL_CYCLES = CNT_W'(stall_cycles);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                state_q;
   logic                  req_q;
   logic [CNT_W-1:0]      timer_q;

   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      err_q, err_d;
   logic                  fev_q, fev_d;
   logic [CNT_W-1:0]      fidx_q, fidx_d;
   logic [data_width-1:0] fdata_q, fdata_d;
   logic [CNT_W-1:0]      extra_q, extra_d;
   logic [CNT_W-1:0]      cycle_q, cycle_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [data_width-1:0] exp_q, exp_d;

   logic                  accept_c;
   logic                  last_c;
   logic                  stall_hit_c;
   logic                  mismatch_c;
   logic                  enter_done_c;
   logic [CNT_W-1:0]      count_inc_c;
   logic [CNT_W-1:0]      stall_inc_c;

   // Decode per-cycle events: acceptance, final item, stall point, mismatch
   always_comb begin
      count_inc_c  = count_q + CNT_W'(1);
      stall_inc_c  = stall_cnt_q + CNT_W'(1);
      // acks count in RUN and STALL whatever req is, since upstream acks lag req
      accept_c     = ack_i && (state_q != ST_DONE) && (MAX_ITEMS != '0);
      last_c       = accept_c && (count_inc_c == MAX_ITEMS);
      stall_hit_c  = accept_c && (STALL_EVERY != '0) && (stall_inc_c == STALL_EVERY);
      mismatch_c   = accept_c && (din_i != exp_q);
      enter_done_c = last_c || ((state_q == ST_RUN) && (MAX_ITEMS == '0));
   end

   // Flow-control FSM: request items, hold req low for stalls, park in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         req_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (enter_done_c) begin
                  state_q <= ST_DONE;
                  req_q   <= 1'b0;
               end else if (stall_hit_c) begin
                  state_q <= ST_STALL;
                  req_q   <= 1'b0;
                  timer_q <= STALL_CYCLES;
               end else begin
                  req_q   <= 1'b1;
               end
            end
            ST_STALL: begin
               if (enter_done_c) begin
                  state_q <= ST_DONE;
                  req_q   <= 1'b0;
                  timer_q <= '0;
               end else if (timer_q <= CNT_W'(1)) begin
                  state_q <= ST_RUN;
                  req_q   <= 1'b1;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q - CNT_W'(1);
               end
            end
            ST_DONE: begin
               req_q <= 1'b0;
            end
            default: begin
               state_q <= ST_RUN;
               req_q   <= 1'b0;
               timer_q <= '0;
            end
         endcase
      end
   end

   // Next values of the scoreboard counters and the incremental golden model
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      count_d     = count_q;
      err_d       = err_q;
      fev_d       = fev_q;
      fidx_d      = fidx_q;
      fdata_d     = fdata_q;
      extra_d     = extra_q;
      cycle_d     = cycle_q;
      exp_d       = exp_q;

      if (accept_c) begin
         count_d = count_inc_c;
         exp_d   = exp_q + EXP_STEP;
         if (STALL_EVERY != '0) begin
            stall_cnt_d = (stall_inc_c == STALL_EVERY) ? '0 : stall_inc_c;
         end
         if (mismatch_c) begin
            err_d = err_q + CNT_W'(1);
            if (!fev_q) begin
               fev_d   = 1'b1;
               fidx_d  = count_q;
               fdata_d = din_i;
            end
         end
      end

      if ((state_q == ST_DONE) && ack_i) begin
         extra_d = extra_q + CNT_W'(1);
      end

      if (!done_q && (cycle_q != '1)) begin
         cycle_d = cycle_q + CNT_W'(1);
      end

      done_d = done_q || enter_done_c;
      pass_d = done_d && (err_d == '0) && (extra_d == '0);
   end

   // Scoreboard registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         count_q     <= '0;
         err_q       <= '0;
         fev_q       <= 1'b0;
         fidx_q      <= '0;
         fdata_q     <= '0;
         extra_q     <= '0;
         cycle_q     <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         exp_q       <= EXP_INIT;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         count_q     <= count_d;
         err_q       <= err_d;
         fev_q       <= fev_d;
         fidx_q      <= fidx_d;
         fdata_q     <= fdata_d;
         extra_q     <= extra_d;
         cycle_q     <= cycle_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         exp_q       <= exp_d;
      end
   end

`ifdef STREAM_CHECKER_TRACE_EN
   // Trace accepted items, mismatches and the completion summary
   always @(posedge clk) begin
      if (!rst) begin
         if (accept_c) begin
            $display("c_%0d, %0d", consumer_id, din_i);
         end
         if (mismatch_c) begin
            $display("MISMATCH c_%0d idx %0d got %0d exp %0d",
                     consumer_id, count_q, din_i, exp_q);
         end
         if (enter_done_c) begin
            $display("c_%0d done count %0d err_count %0d extra_count %0d cycle_count %0d",
                     consumer_id, count_d, err_d, extra_d, cycle_d);
         end
      end
   end
`else
   // Trace disabled: the checker produces no simulation output.
`endif

   assign req_o             = req_q;
   assign count_o           = count_q;
   assign err_count_o       = err_q;
   assign first_err_valid_o = fev_q;
   assign first_err_index_o = fidx_q;
   assign first_err_data_o  = fdata_q;
   assign extra_count_o     = extra_q;
   assign cycle_count_o     = cycle_q;
   assign done_o            = done_q;
   assign pass_o            = pass_q;

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: vector table, hand sequences and a randomized
// run against a behavioural model of the checker's rules.
module tb_stream_checker;

   localparam int unsigned C_START = 10;
   localparam int unsigned C_MUL   = 5;
   localparam int unsigned C_ADD   = 7;
   localparam int unsigned C_MAX   = 200;
   localparam int unsigned C_SE    = 2;
   localparam int unsigned C_SC    = 3;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: identity, 8 items
   logic a_ack, a_req, a_fev, a_done, a_pass;
   logic [31:0] a_din, a_count, a_err, a_fidx, a_fdata, a_extra, a_cyc;
   // instance B: golden 3x+2, 5 items
   logic b_ack, b_req, b_fev, b_done, b_pass;
   logic [31:0] b_din, b_count, b_err, b_fidx, b_fdata, b_extra, b_cyc;
   // instance C: stalls every 2 items for 3 cycles, affine golden
   logic c_ack, c_req, c_fev, c_done, c_pass;
   logic [31:0] c_din, c_count, c_err, c_fidx, c_fdata, c_extra, c_cyc;
   // instance W: 8-bit wrap
   logic w_ack, w_req, w_fev, w_done, w_pass;
   logic [7:0]  w_din, w_fdata;
   logic [31:0] w_count, w_err, w_fidx, w_extra, w_cyc;
   // instance Z: max_items = 0
   logic z_ack, z_req, z_fev, z_done, z_pass;
   logic [31:0] z_din, z_count, z_err, z_fidx, z_fdata, z_extra, z_cyc;

   stream_checker #(.max_items(8)) u_a (
      .clk(clk), .rst(rst), .req_o(a_req), .ack_i(a_ack), .din_i(a_din),
      .count_o(a_count), .err_count_o(a_err), .first_err_valid_o(a_fev),
      .first_err_index_o(a_fidx), .first_err_data_o(a_fdata),
      .extra_count_o(a_extra), .cycle_count_o(a_cyc), .done_o(a_done), .pass_o(a_pass));

   stream_checker #(.exp_mul(3), .exp_add(2), .max_items(5)) u_b (
      .clk(clk), .rst(rst), .req_o(b_req), .ack_i(b_ack), .din_i(b_din),
      .count_o(b_count), .err_count_o(b_err), .first_err_valid_o(b_fev),
      .first_err_index_o(b_fidx), .first_err_data_o(b_fdata),
      .extra_count_o(b_extra), .cycle_count_o(b_cyc), .done_o(b_done), .pass_o(b_pass));

   stream_checker #(.consumer_id(2), .start_value(C_START), .exp_mul(C_MUL), .exp_add(C_ADD),
                    .max_items(C_MAX), .stall_every(C_SE), .stall_cycles(C_SC)) u_c (
      .clk(clk), .rst(rst), .req_o(c_req), .ack_i(c_ack), .din_i(c_din),
      .count_o(c_count), .err_count_o(c_err), .first_err_valid_o(c_fev),
      .first_err_index_o(c_fidx), .first_err_data_o(c_fdata),
      .extra_count_o(c_extra), .cycle_count_o(c_cyc), .done_o(c_done), .pass_o(c_pass));

   stream_checker #(.data_width(8), .start_value(254), .max_items(3)) u_w (
      .clk(clk), .rst(rst), .req_o(w_req), .ack_i(w_ack), .din_i(w_din),
      .count_o(w_count), .err_count_o(w_err), .first_err_valid_o(w_fev),
      .first_err_index_o(w_fidx), .first_err_data_o(w_fdata),
      .extra_count_o(w_extra), .cycle_count_o(w_cyc), .done_o(w_done), .pass_o(w_pass));

   stream_checker #(.max_items(0)) u_z (
      .clk(clk), .rst(rst), .req_o(z_req), .ack_i(z_ack), .din_i(z_din),
      .count_o(z_count), .err_count_o(z_err), .first_err_valid_o(z_fev),
      .first_err_index_o(z_fidx), .first_err_data_o(z_fdata),
      .extra_count_o(z_extra), .cycle_count_o(z_cyc), .done_o(z_done), .pass_o(z_pass));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      a_ack = 1'b0; b_ack = 1'b0; c_ack = 1'b0; w_ack = 1'b0; z_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Behavioural model of instance C, stepped once per clock edge
   logic [31:0] m_count, m_err, m_fidx, m_fdata, m_extra, m_cyc, m_stall_left;
   bit          m_fev, m_done, m_req, m_pass;

   function automatic logic [31:0] gold_c(input logic [31:0] k);
      logic [63:0] v;
      v = 64'(C_MUL) * (64'(C_START) + 64'(k)) + 64'(C_ADD);
      return 32'(v);
   endfunction

   task automatic model_reset();
      m_count = 0; m_err = 0; m_fidx = 0; m_fdata = 0; m_extra = 0; m_cyc = 0;
      m_stall_left = 0; m_fev = 0; m_done = 0; m_req = 0; m_pass = 0;
   endtask

   task automatic model_step(input logic a, input logic [31:0] d);
      bit acc;
      acc = a && !m_done && (C_MAX != 0);
      if (!m_done && m_cyc != 32'hFFFF_FFFF) m_cyc++;
      if (m_done && a) m_extra++;
      if (acc) begin
         if (d != gold_c(m_count)) begin
            m_err++;
            if (!m_fev) begin
               m_fev = 1; m_fidx = m_count; m_fdata = d;
            end
         end
         m_count++;
      end
      if (m_done) begin
         m_req = 0;
      end else if (m_count == C_MAX) begin
         m_done = 1; m_req = 0; m_stall_left = 0;
      end else if (m_stall_left > 0) begin
         m_stall_left--;
         m_req = (m_stall_left == 0);
      end else if (acc && C_SE != 0 && (m_count % C_SE) == 0) begin
         m_stall_left = C_SC;
         m_req = 0;
      end else begin
         m_req = 1;
      end
      m_pass = m_done && m_err == 0 && m_extra == 0;
   endtask

   task automatic compare_c(input string p);
      chk({p, "_req"},   c_req,   m_req);
      chk({p, "_count"}, c_count, m_count);
      chk({p, "_err"},   c_err,   m_err);
      chk({p, "_fev"},   c_fev,   m_fev);
      chk({p, "_fidx"},  c_fidx,  m_fidx);
      chk({p, "_fdata"}, c_fdata, m_fdata);
      chk({p, "_extra"}, c_extra, m_extra);
      chk({p, "_cycle"}, c_cyc,   m_cyc);
      chk({p, "_done"},  c_done,  m_done);
      chk({p, "_pass"},  c_pass,  m_pass);
   endtask

   typedef struct {
      logic        ack;
      logic [31:0] din;
      logic [31:0] e_count;
      logic [31:0] e_extra;
      logic        e_req;
      logic        e_done;
      logic        e_pass;
   } vec_t;

   vec_t tv [18];

   // Hand trace for instance C with an upstream that acks one cycle behind req
   bit          stall_req_exp [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1};
   logic [31:0] stall_cnt_exp [12] = '{0, 0, 1, 2, 3, 3, 3, 3, 4, 5, 5, 5};

   initial begin
      logic        rp1, rp2, ra;
      logic [31:0] rd;
      logic [31:0] b_seq [5];
      logic [7:0]  w_seq [3];

      rst = 1'b1;
      a_ack = 0; b_ack = 0; c_ack = 0; w_ack = 0; z_ack = 0;
      a_din = 0; b_din = 0; c_din = 0; w_din = 0; z_din = 0;

      // identity graph vectors: ack every other cycle, then two extra acks
      for (int i = 0; i < 16; i++) begin
         tv[i].ack     = (i % 2 == 1);
         tv[i].din     = 32'(i / 2);
         tv[i].e_count = 32'((i + 1) / 2);
         tv[i].e_extra = 0;
         tv[i].e_req   = (i != 15);
         tv[i].e_done  = (i == 15);
         tv[i].e_pass  = (i == 15);
      end
      for (int i = 16; i < 18; i++) begin
         tv[i].ack     = 1'b1;
         tv[i].din     = 32'hDEAD;
         tv[i].e_count = 8;
         tv[i].e_extra = 32'(i - 15);
         tv[i].e_req   = 1'b0;
         tv[i].e_done  = 1'b1;
         tv[i].e_pass  = 1'b0;
      end

      // reset state
      do_reset();
      chk("rst_req", a_req, 0);
      chk("rst_count", a_count, 0);
      chk("rst_err", a_err, 0);
      chk("rst_fev", a_fev, 0);
      chk("rst_cycle", a_cyc, 0);
      chk("rst_done", a_done, 0);
      chk("rst_pass", a_pass, 0);
      chk("rst_w_fdata", w_fdata, 0);

      for (int i = 0; i < 18; i++) begin
         a_ack = tv[i].ack;
         a_din = tv[i].din;
         tick();
         chk($sformatf("id_count[%0d]", i), a_count, tv[i].e_count);
         chk($sformatf("id_req[%0d]", i),   a_req,   tv[i].e_req);
         chk($sformatf("id_done[%0d]", i),  a_done,  tv[i].e_done);
         chk($sformatf("id_pass[%0d]", i),  a_pass,  tv[i].e_pass);
         chk($sformatf("id_extra[%0d]", i), a_extra, tv[i].e_extra);
      end
      a_ack = 0;
      tick();
      chk("id_err", a_err, 0);
      chk("id_cycle_frozen", a_cyc, 16);
      chk("id_req_low", a_req, 0);

      // reset mid-stream at count 3, with ack high during reset
      do_reset();
      a_ack = 1;
      for (int k = 0; k < 3; k++) begin
         a_din = 32'(k);
         tick();
      end
      chk("mid_count_pre", a_count, 3);
      rst = 1'b1;
      a_din = 3;
      tick();
      chk("mid_count", a_count, 0);
      chk("mid_cycle", a_cyc, 0);
      chk("mid_req", a_req, 0);
      chk("mid_done", a_done, 0);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a_din = 32'(k);
         tick();
      end
      a_ack = 0;
      chk("mid_restart_count", a_count, 2);
      chk("mid_restart_err", a_err, 0);
      chk("mid_restart_req", a_req, 1);

      // golden 3x+2 with a single bad item at index 3
      b_seq = '{2, 5, 8, 12, 14};
      do_reset();
      b_ack = 1;
      for (int k = 0; k < 5; k++) begin
         b_din = b_seq[k];
         tick();
         if (k == 2) chk("g_err_before", b_err, 0);
      end
      b_ack = 0;
      chk("g_count", b_count, 5);
      chk("g_err", b_err, 1);
      chk("g_fev", b_fev, 1);
      chk("g_fidx", b_fidx, 3);
      chk("g_fdata", b_fdata, 12);
      chk("g_done", b_done, 1);
      chk("g_pass", b_pass, 0);

      // 8-bit wrap of the golden sequence
      w_seq = '{8'd254, 8'd255, 8'd0};
      do_reset();
      w_ack = 1;
      for (int k = 0; k < 3; k++) begin
         w_din = w_seq[k];
         tick();
      end
      w_ack = 0;
      chk("wrap_count", w_count, 3);
      chk("wrap_err", w_err, 0);
      chk("wrap_pass", w_pass, 1);

      // max_items = 0: done on the first cycle, req never raised
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("zero_req[%0d]", k), z_req, 0);
         chk($sformatf("zero_done[%0d]", k), z_done, 1);
      end
      chk("zero_count", z_count, 0);
      chk("zero_pass", z_pass, 1);

      // stalls with a registered upstream: ack follows req one cycle later
      do_reset();
      model_reset();
      rp1 = 0;
      rp2 = 0;
      for (int k = 0; k < 12; k++) begin
         c_ack = rp2;
         c_din = gold_c(m_count);
         tick();
         model_step(c_ack, c_din);
         chk($sformatf("stall_req[%0d]", k), c_req, stall_req_exp[k]);
         chk($sformatf("stall_count[%0d]", k), c_count, stall_cnt_exp[k]);
         rp2 = rp1;
         rp1 = c_req;
      end
      chk("stall_err", c_err, 0);

      // randomized acks and occasional corrupted items, one reset midway
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 700; cyc++) begin
         if (cyc == 350) begin
            rst   = 1'b1;
            c_ack = 1'($urandom_range(0, 1));
            tick();
            model_reset();
            rst = 1'b0;
            compare_c("rnd_rst");
         end else begin
            ra = ($urandom_range(0, 3) != 0);
            rd = gold_c(m_count);
            if ($urandom_range(0, 15) == 0) rd = rd ^ (32'd1 << $urandom_range(0, 31));
            c_ack = ra;
            c_din = rd;
            tick();
            model_step(ra, rd);
            compare_c("rnd");
         end
      end
      c_ack = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
